seq_bin2bcd: RTL and testbench
==============================

Name: seq_bin2bcd

Overview:
Parametrised, multi-cycle binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Generalised successor of the fixed 8-bit combinational converter: arbitrary input width, ready/valid handshakes on both sides, registered output, significant-digit count.
- Sits between a binary data source and a digit display or serial-out stage in the tile's IO path.

Parameters:
- BIN_W, 8, binary input width in bits (>=2).
- DIGITS, 3, BCD output digits. Must be >= ceil(BIN_W*log10(2)). Elaboration-time error if smaller.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  source offers in_data.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_data  in  BIN_W  binary operand.
- out_valid  out  1  out_bcd/out_ndigits/out_neg valid.
- out_ready  in  1  sink accepts result.
- out_bcd  out  4*DIGITS  packed BCD; digit k at [4k+3:4k], k=0 least significant.
- out_ndigits  out  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS (value 0 reports 1).
- out_neg  out  1  sign flag (see Optional Feature); constant 0 when feature absent.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, work registers=0.
  - out_bcd=0, out_ndigits=1, out_neg=0, out_valid=0.
  - in_ready=1 in the cycle after reset.
  - Reset overrides all other activity, including mid-conversion; an in-flight conversion is dropped with no output.
- FSM states IDLE, SHIFT, DONE:
  - IDLE:
    - in_ready=1.
    - On edge with in_valid=1: latch in_data into shift reg, clear BCD work reg, bit counter=BIN_W, go to SHIFT.
  - SHIFT:
    - in_ready=0.
    - Each edge: every work digit >=5 gets +3 (4-bit, no carry out of digit), then {bcd,shift} shifted left 1, counter decremented.
    - On edge where counter goes 1->0: copy work BCD to out_bcd, compute out_ndigits (index of highest nonzero digit +1, min 1), go to DONE.
  - DONE:
    - out_valid=1; out_* stable.
    - On edge with out_ready=1: go to IDLE, out_valid=0.
    - out_ready=0 holds DONE indefinitely, outputs unchanged.
- Latency: accept at edge E0 -> out_valid high after edge E0+BIN_W (BIN_W cycles).
- Minimum initiation interval BIN_W+2 cycles. No overlap, no input buffering.
- out_bcd/out_ndigits/out_neg keep the last result after handshake until the next conversion completes.
- in_valid during SHIFT/DONE is ignored; the source must hold it until in_ready.
- No overflow is possible given the DIGITS constraint; unused top digits read 0.
- Simultaneous rst and in_valid: reset wins, nothing accepted.

Optional Feature:
Macro SEQ_BIN2BCD_SIGNED_EN.
- Defined:
  - in_data is two's complement.
  - On accept, the magnitude is loaded: -x for negative inputs, computed in BIN_W bits as unsigned, so -2^(BIN_W-1) gives 2^(BIN_W-1).
  - out_neg=sign bit, registered with out_bcd at SHIFT->DONE.
  - Negative zero is impossible.
- Undefined:
  - in_data is unsigned.
  - out_neg tied 0.
- Latency is identical in both builds.

Test Plan:
- BIN_W=8, in_data=255, out_ready=1 -> out_valid exactly 8 cycles after accept, out_bcd=12'h255, out_ndigits=3, then in_ready=1 the cycle after handshake.
- in_data=0 -> out_bcd=12'h000, out_ndigits=1. in_data=9 -> 12'h009, ndigits=1. in_data=100 -> 12'h100, ndigits=3.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_bcd/out_valid stable, in_ready=0, pulsed in_valid ignored. Release -> IDLE next edge.
- Reset at 4th SHIFT cycle -> next cycle out_valid=0, in_ready=1, out_bcd=0. New input 42 -> 12'h042 after 8 cycles.
- BIN_W=16, DIGITS=5: 65535 -> 20'h65535, ndigits=5, latency 16. 1000 -> 20'h01000, ndigits=4.
- SIGNED_EN, BIN_W=8: 8'h80 -> out_neg=1, 12'h128. 8'hFF -> out_neg=1, 12'h001. 8'h7F -> out_neg=0, 12'h127.

Source files
------------

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: multi-cycle binary-to-BCD converter, one bit per clock.
// Shift-add-3 (double dabble) with ready/valid on both sides.
//
// Parameters:
//   BIN_W   binary input width (>=2)
//   DIGITS  BCD digits; must cover 2^BIN_W-1 (checked at elaboration)
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready high only while idle
//   in_data         binary operand
//   out_valid/ready output handshake; result held until accepted
//   out_bcd         packed BCD, digit k at [4k+3:4k]
//   out_ndigits     significant digit count, 1..DIGITS
//   out_neg         sign of the operand (signed build), else 0
// Build option:
//   SEQ_BIN2BCD_SIGNED_EN  treat in_data as two's complement and
//                          convert its magnitude
module seq_bin2bcd #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIN_W-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  out_ndigits,
  output logic                         out_neg
);

  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = $clog2(BIN_W + 1);
  localparam int NDW  = $clog2(DIGITS + 1);

  // Digits needed for 2^n-1 equals ceil(n*log10(2)); the scaled
  // constant slightly exceeds log10(2) so the ceiling never comes short.
  function automatic int min_digits(input int n);
    logic [63:0] t;
    t = 64'(n) * 64'd301029996;
    return int'((t + 64'd999999999) / 64'd1000000000);
  endfunction

  if (BIN_W < 2) begin : g_bad_w
    $error("seq_bin2bcd: BIN_W must be >= 2");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_bad_d
    $error("seq_bin2bcd: DIGITS too small for BIN_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [BIN_W-1:0]  r_shift;
  logic [BW-1:0]     r_work;
  logic [CNTW-1:0]   r_cnt;
  logic              r_sign;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [BW-1:0]     r_out_bcd;
  logic [NDW-1:0]    r_out_nd;
  logic              r_out_neg;

  logic [BIN_W-1:0]  w_mag;
  logic              w_sign;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_next;
  logic [NDW-1:0]    w_nd;
  logic              w_unused;

`ifdef SEQ_BIN2BCD_SIGNED_EN
  // Unsigned BIN_W-bit negate: the most negative value maps
  // onto its own bit pattern, which read unsigned is 2^(BIN_W-1).
  assign w_sign = in_data[BIN_W-1];
  assign w_mag  = w_sign ? (~in_data + BIN_W'(1)) : in_data;
`else
  assign w_sign = 1'b0;
  assign w_mag  = in_data;
`endif

  // Pre-shift correction: digits >= 5 would exceed 9 after doubling.
  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_next = {w_adj[BW-2:0], r_shift[BIN_W-1]};

  // The DIGITS bound guarantees the top bit is never set here.
  assign w_unused = w_adj[BW-1];

  // Highest nonzero digit of the final value; zero reports one digit.
  always_comb begin
    w_nd = NDW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      if (w_next[4*k +: 4] != 4'd0) begin
        w_nd = NDW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_bcd   <= '0;
      r_out_nd    <= NDW'(1);
      r_out_neg   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift    <= w_mag;
            r_work     <= '0;
            r_cnt      <= CNTW'(BIN_W);
            r_sign     <= w_sign;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_work  <= w_next;
          r_shift <= {r_shift[BIN_W-2:0], 1'b0};
          r_cnt   <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) begin
            r_out_bcd   <= w_next;
            r_out_nd    <= w_nd;
            r_out_neg   <= r_sign;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_bcd     = r_out_bcd;
  assign out_ndigits = r_out_nd;
  assign out_neg     = r_out_neg;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// tb_seq_bin2bcd: directed vectors for seq_bin2bcd at 8 and 16 bits.
// Covers latency, backpressure, and reset interactions.
module tb_seq_bin2bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0, rdy8, ov8, or8 = 1'b1, neg8;
  logic [7:0]  d8 = '0;
  logic [11:0] bcd8;
  logic [1:0]  nd8;

  logic        iv16 = 1'b0, rdy16, ov16, or16 = 1'b1, neg16;
  logic [15:0] d16 = '0;
  logic [19:0] bcd16;
  logic [2:0]  nd16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_bin2bcd #(.BIN_W(8), .DIGITS(3)) u_d8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(rdy8), .in_data(d8),
    .out_valid(ov8), .out_ready(or8),
    .out_bcd(bcd8), .out_ndigits(nd8), .out_neg(neg8)
  );

  seq_bin2bcd #(.BIN_W(16), .DIGITS(5)) u_d16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(rdy16), .in_data(d16),
    .out_valid(ov16), .out_ready(or16),
    .out_bcd(bcd16), .out_ndigits(nd16), .out_neg(neg16)
  );

  typedef struct {
    logic [15:0] din;
    logic [19:0] bcd;
    int          nd;
    bit          neg;
  } vec_t;

  vec_t v8[8];
  vec_t v16[3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_conv(input bit w16, input logic [15:0] d,
                         input logic [19:0] eb, input int en,
                         input bit eneg, input string tag);
    int n;
    n = 0;
    while (!(w16 ? rdy16 : rdy8) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " rdy"}, 32'(w16 ? rdy16 : rdy8), 32'd1);
    if (w16) begin
      iv16 = 1'b1;
      d16  = d;
    end else begin
      iv8 = 1'b1;
      d8  = d[7:0];
    end
    tick();
    iv8  = 1'b0;
    iv16 = 1'b0;
    n = 0;
    while (!(w16 ? ov16 : ov8) && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " lat"}, 32'(n), w16 ? 32'd16 : 32'd8);
    chk({tag, " bcd"}, w16 ? 32'(bcd16) : 32'(bcd8), 32'(eb));
    chk({tag, " nd"}, w16 ? 32'(nd16) : 32'(nd8), 32'(en));
    chk({tag, " neg"}, 32'(w16 ? neg16 : neg8), 32'(eneg));
    tick();
    chk({tag, " ov_after"}, 32'(w16 ? ov16 : ov8), 32'd0);
    chk({tag, " rdy_after"}, 32'(w16 ? rdy16 : rdy8), 32'd1);
  endtask

  initial begin
    int  n;
    bit  seen;

`ifdef SEQ_BIN2BCD_SIGNED_EN
    v8[0] = '{16'h0080, 20'h128, 3, 1'b1};
    v8[1] = '{16'h00FF, 20'h001, 1, 1'b1};
    v8[2] = '{16'h007F, 20'h127, 3, 1'b0};
    v8[3] = '{16'd0,    20'h000, 1, 1'b0};
    v8[4] = '{16'd9,    20'h009, 1, 1'b0};
    v8[5] = '{16'd100,  20'h100, 3, 1'b0};
    v8[6] = '{16'h00D6, 20'h042, 2, 1'b1};
    v8[7] = '{16'h009C, 20'h100, 3, 1'b1};
    v16[0] = '{16'hFFFF, 20'h00001, 1, 1'b1};
    v16[1] = '{16'd1000, 20'h01000, 4, 1'b0};
    v16[2] = '{16'h8000, 20'h32768, 5, 1'b1};
`else
    v8[0] = '{16'd255,  20'h255, 3, 1'b0};
    v8[1] = '{16'd0,    20'h000, 1, 1'b0};
    v8[2] = '{16'd9,    20'h009, 1, 1'b0};
    v8[3] = '{16'd100,  20'h100, 3, 1'b0};
    v8[4] = '{16'd42,   20'h042, 2, 1'b0};
    v8[5] = '{16'd128,  20'h128, 3, 1'b0};
    v8[6] = '{16'd127,  20'h127, 3, 1'b0};
    v8[7] = '{16'd10,   20'h010, 2, 1'b0};
    v16[0] = '{16'd65535, 20'h65535, 5, 1'b0};
    v16[1] = '{16'd1000,  20'h01000, 4, 1'b0};
    v16[2] = '{16'h8000,  20'h32768, 5, 1'b0};
`endif

    tick();
    tick();
    chk("rst ov8", 32'(ov8), 32'd0);
    chk("rst rdy8", 32'(rdy8), 32'd1);
    chk("rst bcd8", 32'(bcd8), 32'h0);
    chk("rst nd8", 32'(nd8), 32'd1);
    chk("rst neg8", 32'(neg8), 32'd0);
    chk("rst nd16", 32'(nd16), 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_conv(1'b0, v8[i].din, v8[i].bcd, v8[i].nd, v8[i].neg,
              $sformatf("v8[%0d]", i));
    end
    for (int i = 0; i < 3; i++) begin
      do_conv(1'b1, v16[i].din, v16[i].bcd, v16[i].nd, v16[i].neg,
              $sformatf("v16[%0d]", i));
    end

    // Backpressure: hold DONE, pulse in_valid, nothing moves.
    or8 = 1'b0;
    iv8 = 1'b1;
    d8  = 8'd123;
    tick();
    iv8 = 1'b0;
    n = 0;
    while (!ov8 && n < 100) begin
      tick();
      n++;
    end
    chk("bp lat", 32'(n), 32'd8);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1;
      d8  = 8'(50 + i);
      tick();
      chk($sformatf("bp ov[%0d]", i), 32'(ov8), 32'd1);
      chk($sformatf("bp bcd[%0d]", i), 32'(bcd8), 32'h123);
      chk($sformatf("bp rdy[%0d]", i), 32'(rdy8), 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    chk("bp rel ov", 32'(ov8), 32'd0);
    chk("bp rel rdy", 32'(rdy8), 32'd1);
    chk("bp hold bcd", 32'(bcd8), 32'h123);
    chk("bp hold nd", 32'(nd8), 32'd3);

    // Reset in the 4th SHIFT cycle drops the conversion.
    iv8 = 1'b1;
    d8  = 8'd99;
    tick();
    iv8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst ov", 32'(ov8), 32'd0);
    chk("mid rst rdy", 32'(rdy8), 32'd1);
    chk("mid rst bcd", 32'(bcd8), 32'h0);
    chk("mid rst nd", 32'(nd8), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ov8) seen = 1'b1;
    end
    chk("mid rst no out", 32'(seen), 32'd0);
    do_conv(1'b0, 16'd42, 20'h042, 2, 1'b0, "post rst 42");

    // Reset and in_valid together: reset wins.
    rst = 1'b1;
    iv8 = 1'b1;
    d8  = 8'd77;
    tick();
    rst = 1'b0;
    iv8 = 1'b0;
    chk("rst+iv rdy", 32'(rdy8), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov8 || !rdy8) seen = 1'b1;
    end
    chk("rst+iv idle", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
